log_dot_accumulator: RTL and testbench

//   Sequential consumer sitting directly downstream of log_multiplier.

---
 rtl/log_dot_accumulator.sv | 88 ++++++++
 tb/tb_log_dot_accumulator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/log_dot_accumulator.sv
// Saturating dot-product accumulator fed by log_multiplier products over valid/ready.
// Result appears one cycle after the last beat and is held until the downstream takes it.
module log_dot_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic              acc_overflow,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] count;
  logic [ACC_W:0]   sum;

  // One extra bit so a carry out of ACC_W flags saturation.
  assign sum = {1'b0, acc_data} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      len          <= '0;
      count        <= '0;
      prod_ready   <= 1'b0;
      acc_valid    <= 1'b0;
      acc_data     <= '0;
      acc_overflow <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count        <= '0;
            acc_data     <= '0;
            acc_overflow <= 1'b0;
            busy         <= 1'b1;
            if (vec_len != '0) begin
              len        <= vec_len;
              state      <= ACCUM;
              prod_ready <= 1'b1;
            end else begin
              state     <= DONE;
              acc_valid <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (prod_valid && prod_ready) begin
            if (sum[ACC_W]) begin
              acc_data     <= '1;
              acc_overflow <= 1'b1;
            end else begin
              acc_data <= sum[ACC_W-1:0];
            end
            count <= count + 1'b1;
            if (count == len - 1'b1) begin
              state      <= DONE;
              prod_ready <= 1'b0;
              acc_valid  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (acc_ready) begin
            state     <= IDLE;
            acc_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_log_dot_accumulator.sv
// Directed bench for log_dot_accumulator: two instances (ACC_W=24 and ACC_W=17) share stimulus
// and are compared every cycle against a count-down/saturating-sum model.
module tb_log_dot_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  vec_len = '0;
  logic        prod_valid = 1'b0;
  logic [15:0] prod_data = '0;
  logic        acc_ready = 1'b0;

  logic        ready_a, valid_a, ovf_a, busy_a;
  logic [23:0] data_a;
  logic        ready_b, valid_b, ovf_b, busy_b;
  logic [16:0] data_b;

  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  log_dot_accumulator #(.PROD_W(16), .ACC_W(24), .LEN_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
    .prod_valid(prod_valid), .prod_ready(ready_a), .prod_data(prod_data),
    .acc_valid(valid_a), .acc_ready(acc_ready), .acc_data(data_a),
    .acc_overflow(ovf_a), .busy(busy_a)
  );

  log_dot_accumulator #(.PROD_W(16), .ACC_W(17), .LEN_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
    .prod_valid(prod_valid), .prod_ready(ready_b), .prod_data(prod_data),
    .acc_valid(valid_b), .acc_ready(acc_ready), .acc_data(data_b),
    .acc_overflow(ovf_b), .busy(busy_b)
  );

  // Model: beats still owed, a pending result, and saturating sums for both widths.
  int     m_rem = 0;
  bit     m_result = 1'b0;
  longint m_sum_a = 0, m_sum_b = 0;
  bit     m_ovf_a = 1'b0, m_ovf_b = 1'b0;
  localparam longint MAX_A = (64'd1 << 24) - 1;
  localparam longint MAX_B = (64'd1 << 17) - 1;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_rem = 0; m_result = 1'b0;
      m_sum_a = 0; m_sum_b = 0; m_ovf_a = 1'b0; m_ovf_b = 1'b0;
    end else if (m_result) begin
      if (acc_ready) m_result = 1'b0;
    end else if (m_rem > 0) begin
      if (prod_valid) begin
        m_sum_a = m_sum_a + prod_data;
        m_sum_b = m_sum_b + prod_data;
        if (m_sum_a > MAX_A) begin m_sum_a = MAX_A; m_ovf_a = 1'b1; end
        if (m_sum_b > MAX_B) begin m_sum_b = MAX_B; m_ovf_b = 1'b1; end
        m_rem = m_rem - 1;
        if (m_rem == 0) m_result = 1'b1;
      end
    end else if (start) begin
      m_sum_a = 0; m_sum_b = 0; m_ovf_a = 1'b0; m_ovf_b = 1'b0;
      if (vec_len == 0) m_result = 1'b1;
      else m_rem = int'(vec_len);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a.prod_ready", 64'(ready_a), 64'(m_rem > 0));
      check("a.acc_valid",  64'(valid_a), 64'(m_result));
      check("a.acc_data",   64'(data_a),  64'(m_sum_a));
      check("a.overflow",   64'(ovf_a),   64'(m_ovf_a));
      check("a.busy",       64'(busy_a),  64'(m_rem > 0 || m_result));
      check("b.prod_ready", 64'(ready_b), 64'(m_rem > 0));
      check("b.acc_valid",  64'(valid_b), 64'(m_result));
      check("b.acc_data",   64'(data_b),  64'(m_sum_b));
      check("b.overflow",   64'(ovf_b),   64'(m_ovf_b));
      check("b.busy",       64'(busy_b),  64'(m_rem > 0 || m_result));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_vec(input logic [7:0] len);
    start = 1'b1; vec_len = len;
    tick();
    start = 1'b0; vec_len = '0;
  endtask

  task automatic beat(input logic [15:0] p, input int gap);
    prod_valid = 1'b1; prod_data = p;
    tick();
    prod_valid = 1'b0; prod_data = '0;
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic take();
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("reset.valid", 64'(valid_a), 64'd0);
    check("reset.data",  64'(data_a),  64'd0);

    // Test 1: 32+32+32
    begin_vec(8'd3);
    beat(16'd32, 0); beat(16'd32, 0); beat(16'd32, 0);
    check("t1.valid", 64'(valid_a), 64'd1);
    check("t1.data",  64'(data_a),  64'd96);
    check("t1.model", 64'(m_sum_a), 64'd96);
    check("t1.ovf",   64'(ovf_a),   64'd0);
    take();
    check("t1.held_data", 64'(data_a),  64'd96);
    check("t1.dropped",   64'(valid_a), 64'd0);

    // Test 2: gapped beats, then result held under backpressure
    begin_vec(8'd4);
    beat(16'd10, 2); beat(16'd20, 2); beat(16'd30, 2); beat(16'd40, 0);
    check("t2.model", 64'(m_sum_a), 64'd100);
    for (int i = 0; i < 5; i++) begin
      check("t2.hold_data",  64'(data_a),  64'd100);
      check("t2.hold_valid", 64'(valid_a), 64'd1);
      tick();
    end
    take();

    // Test 3: saturation on the 17-bit instance, not on the 24-bit one
    begin_vec(8'd3);
    beat(16'hFFFF, 0); beat(16'hFFFF, 0); beat(16'hFFFF, 0);
    check("t3.b_data",  64'(data_b),  64'h1FFFF);
    check("t3.b_ovf",   64'(ovf_b),   64'd1);
    check("t3.a_data",  64'(data_a),  64'h2FFFD);
    check("t3.a_ovf",   64'(ovf_a),   64'd0);
    check("t3.model",   64'(m_sum_b), 64'h1FFFF);
    take();
    tick();
    check("t3.ovf_sticky", 64'(ovf_b), 64'd1);

    // Test 4: zero-length vector
    begin_vec(8'd0);
    check("t4.valid", 64'(valid_a), 64'd1);
    check("t4.data",  64'(data_a),  64'd0);
    check("t4.ready", 64'(ready_a), 64'd0);
    check("t4.ovf",   64'(ovf_b),   64'd0);
    take();

    // Test 5: reset mid-vector, then a single beat
    begin_vec(8'd4);
    beat(16'd7, 0); beat(16'd9, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5.rst_ready", 64'(ready_a), 64'd0);
    check("t5.rst_busy",  64'(busy_a),  64'd0);
    check("t5.rst_data",  64'(data_a),  64'd0);
    begin_vec(8'd1);
    beat(16'd5, 0);
    check("t5.data", 64'(data_a), 64'd5);
    check("t5.ovf",  64'(ovf_a),  64'd0);
    take();

    // Test 6: start during ACCUM is ignored
    begin_vec(8'd2);
    beat(16'd7, 0);
    start = 1'b1; vec_len = 8'd9;
    tick();
    start = 1'b0; vec_len = '0;
    beat(16'd8, 0);
    check("t6.valid", 64'(valid_a), 64'd1);
    check("t6.data",  64'(data_a),  64'd15);
    take();
    for (int i = 0; i < 4; i++) begin
      check("t6.idle_ready", 64'(ready_a), 64'd0);
      tick();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
